// File: rtl/decode_stage.sv
// Decode stage: per-lane combinational decode into a registered output with an optional one-entry skid.
// Optional macro DECODE_LOGIC_IMM_EXT_EN adds ANDI, XORI and LUI to the legal opcode set.
package decode_pkg;
  typedef enum logic [1:0] {alu_or, alu_add, alu_and, alu_xor} alu_op_t;
  typedef enum logic [1:0] {nbc, bc_eq, bc_ne, bc_ltz} bc_op_t;
  typedef enum logic [1:0] {llu_nop, llu_mul, llu_div, llu_mfhi} llu_op_t;
  typedef enum logic {wrd, wrm} wr_src_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] predict_pc_addr;
    logic        predict_brunch_taken;
  } decode_req_t;

  typedef struct packed {
    logic        num1_need;
    logic [4:0]  num1_addr;
    logic [31:0] num1;
    logic        num2_need;
    logic [4:0]  num2_addr;
    logic [31:0] num2;
    alu_op_t     alu_op;
    bc_op_t      bc_op;
    llu_op_t     llu_op;
    logic        mem_read;
    logic        mem_write;
    wr_src_t     wr_src;
    logic        write_reg_need;
    logic [4:0]  write_reg_addr;
    logic [31:0] pc;
    logic [31:0] predict_pc_addr;
    logic        predict_brunch_taken;
    logic [2:0]  accept_mask;
  } issue_elem_t;

  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  function automatic issue_elem_t elem_default();
    issue_elem_t e;
    e             = '0;
    e.alu_op      = alu_or;
    e.bc_op       = nbc;
    e.llu_op      = llu_nop;
    e.wr_src      = wrd;
    e.accept_mask = 3'b111;
    return e;
  endfunction
endpackage

module decode_lane
  import decode_pkg::*;
(
  input  decode_req_t i_req,
  input  logic        i_slot_valid,
  output issue_elem_t o_elem,
  output logic        o_illegal
);
  logic [5:0]  w_op;
  logic [4:0]  w_rs, w_rt;
  logic [15:0] w_imm;
  assign {w_op, w_rs, w_rt, w_imm} = i_req.inst;

  always_comb begin
    o_elem    = elem_default();
    o_illegal = 1'b0;
    if (i_slot_valid) begin
      o_elem.pc                   = i_req.pc;
      o_elem.predict_pc_addr      = i_req.predict_pc_addr;
      o_elem.predict_brunch_taken = i_req.predict_brunch_taken;
      case (w_op)
        OP_ORI: begin
          o_elem.num1_need      = 1'b1;
          o_elem.num1_addr      = w_rs;
          o_elem.num2           = {16'h0, w_imm};
          o_elem.write_reg_need = 1'b1;
          o_elem.write_reg_addr = w_rt;
        end
        OP_ADDIU: begin
          o_elem.num1_need      = 1'b1;
          o_elem.num1_addr      = w_rs;
          o_elem.num2           = {{16{w_imm[15]}}, w_imm};
          o_elem.alu_op         = alu_add;
          o_elem.write_reg_need = 1'b1;
          o_elem.write_reg_addr = w_rt;
        end
`ifdef DECODE_LOGIC_IMM_EXT_EN
        OP_ANDI, OP_XORI: begin
          o_elem.num1_need      = 1'b1;
          o_elem.num1_addr      = w_rs;
          o_elem.num2           = {16'h0, w_imm};
          o_elem.alu_op         = (w_op == OP_ANDI) ? alu_and : alu_xor;
          o_elem.write_reg_need = 1'b1;
          o_elem.write_reg_addr = w_rt;
        end
        OP_LUI: begin
          o_elem.num2           = {w_imm, 16'h0};
          o_elem.write_reg_need = 1'b1;
          o_elem.write_reg_addr = w_rt;
        end
`endif
        default: o_illegal = 1'b1;
      endcase
    end
  end
endmodule

module decode_stage
  import decode_pkg::*;
#(
  parameter int DECODE_WIDTH  = 2,
  parameter int SKID_EN_DEPTH = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  decode_req_t [DECODE_WIDTH-1:0] in_req,
  input  logic        [DECODE_WIDTH-1:0] in_slot_valid,
  output logic                           out_valid,
  input  logic                           out_ready,
  output issue_elem_t [DECODE_WIDTH-1:0] out_elem,
  output logic        [DECODE_WIDTH-1:0] out_slot_valid,
  output logic        [DECODE_WIDTH-1:0] out_illegal
);
  issue_elem_t [DECODE_WIDTH-1:0] w_elem, r_out_elem;
  logic        [DECODE_WIDTH-1:0] w_ill, r_out_slot, r_out_ill;
  logic                           r_out_valid, w_acc, w_drain;

  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_lane
    decode_lane u_lane (
      .i_req       (in_req[g]),
      .i_slot_valid(in_slot_valid[g]),
      .o_elem      (w_elem[g]),
      .o_illegal   (w_ill[g])
    );
  end

  // Empty bundles are accepted but never occupy a register.
  assign w_acc   = in_valid && in_ready && !flush && (|in_slot_valid);
  assign w_drain = r_out_valid && out_ready;

  if (SKID_EN_DEPTH == 1) begin : g_skid
    issue_elem_t [DECODE_WIDTH-1:0] r_skid_elem;
    logic        [DECODE_WIDTH-1:0] r_skid_slot, r_skid_ill;
    logic                           r_skid_valid, r_in_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_out_valid  <= 1'b0;
        r_out_slot   <= '0;
        r_out_ill    <= '0;
        r_skid_valid <= 1'b0;
        r_skid_slot  <= '0;
        r_skid_ill   <= '0;
        r_in_ready   <= 1'b0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
          r_out_elem[i]  <= elem_default();
          r_skid_elem[i] <= elem_default();
        end
      end else if (flush) begin
        r_out_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (!r_out_valid || w_drain) begin
        // in_ready is low whenever the skid holds data, so skid and accept never collide.
        if (r_skid_valid) begin
          r_out_elem   <= r_skid_elem;
          r_out_slot   <= r_skid_slot;
          r_out_ill    <= r_skid_ill;
          r_out_valid  <= 1'b1;
          r_skid_valid <= 1'b0;
        end else if (w_acc) begin
          r_out_elem  <= w_elem;
          r_out_slot  <= in_slot_valid;
          r_out_ill   <= w_ill;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
        r_in_ready <= 1'b1;
      end else if (w_acc) begin
        r_skid_elem  <= w_elem;
        r_skid_slot  <= in_slot_valid;
        r_skid_ill   <= w_ill;
        r_skid_valid <= 1'b1;
        r_in_ready   <= 1'b0;
      end
    end
    assign in_ready = r_in_ready;
  end else begin : g_noskid
    logic r_rst_done;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rst_done  <= 1'b0;
        r_out_valid <= 1'b0;
        r_out_slot  <= '0;
        r_out_ill   <= '0;
        for (int i = 0; i < DECODE_WIDTH; i++) r_out_elem[i] <= elem_default();
      end else begin
        r_rst_done <= 1'b1;
        if (flush) begin
          r_out_valid <= 1'b0;
        end else if (w_acc) begin
          r_out_elem  <= w_elem;
          r_out_slot  <= in_slot_valid;
          r_out_ill   <= w_ill;
          r_out_valid <= 1'b1;
        end else if (in_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
    assign in_ready = r_rst_done && (!r_out_valid || out_ready);
  end

  assign out_valid      = r_out_valid;
  assign out_elem       = r_out_elem;
  assign out_slot_valid = r_out_slot;
  assign out_illegal    = r_out_ill;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage (2 lanes, skid on): directed scenarios then random traffic against a bundle-queue model.
module tb_decode_stage;
  import decode_pkg::*;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  decode_req_t [W-1:0] in_req;
  logic        [W-1:0] in_slot_valid, out_slot_valid, out_illegal;
  issue_elem_t [W-1:0] out_elem;

  typedef struct {
    issue_elem_t [W-1:0] e;
    logic        [W-1:0] sv;
    logic        [W-1:0] ill;
  } bundle_t;

  bundle_t q[$];
  int      checks = 0, failures = 0;
  bit      rst_done = 1'b0;

  always #5 clk = ~clk;

  decode_stage #(.DECODE_WIDTH(W), .SKID_EN_DEPTH(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_req(in_req), .in_slot_valid(in_slot_valid), .out_valid(out_valid),
    .out_ready(out_ready), .out_elem(out_elem), .out_slot_valid(out_slot_valid),
    .out_illegal(out_illegal)
  );

  function automatic issue_elem_t dflt();
    issue_elem_t e = '0;
    e.alu_op = alu_or; e.bc_op = nbc; e.llu_op = llu_nop; e.wr_src = wrd;
    e.accept_mask = 3'b111;
    return e;
  endfunction

  // Reference: what the issue queue should see for each lane, from opcode semantics.
  function automatic bundle_t expect_bundle(input decode_req_t [W-1:0] r, input logic [W-1:0] sv);
    bundle_t b;
    for (int i = 0; i < W; i++) begin
      logic [5:0] op; logic [15:0] imm; logic [4:0] rs, rt;
      b.e[i] = dflt(); b.ill[i] = 1'b0; b.sv[i] = sv[i];
      op = r[i].inst[31:26]; rs = r[i].inst[25:21]; rt = r[i].inst[20:16]; imm = r[i].inst[15:0];
      if (sv[i]) begin
        b.e[i].pc = r[i].pc;
        b.e[i].predict_pc_addr = r[i].predict_pc_addr;
        b.e[i].predict_brunch_taken = r[i].predict_brunch_taken;
        if (op == 6'h0D || op == 6'h09) begin
          b.e[i].num1_need = 1'b1; b.e[i].num1_addr = rs;
          b.e[i].write_reg_need = 1'b1; b.e[i].write_reg_addr = rt;
          b.e[i].num2 = (op == 6'h0D) ? 32'(imm) : 32'($signed(imm));
          b.e[i].alu_op = (op == 6'h0D) ? alu_or : alu_add;
        end
`ifdef DECODE_LOGIC_IMM_EXT_EN
        else if (op == 6'h0C || op == 6'h0E) begin
          b.e[i].num1_need = 1'b1; b.e[i].num1_addr = rs;
          b.e[i].write_reg_need = 1'b1; b.e[i].write_reg_addr = rt;
          b.e[i].num2 = 32'(imm);
          b.e[i].alu_op = (op == 6'h0C) ? alu_and : alu_xor;
        end else if (op == 6'h0F) begin
          b.e[i].num2 = 32'(imm) << 16;
          b.e[i].write_reg_need = 1'b1; b.e[i].write_reg_addr = rt;
        end
`endif
        else b.ill[i] = 1'b1;
      end
    end
    return b;
  endfunction

  function automatic decode_req_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] imm);
    decode_req_t r;
    r.pc = $urandom; r.inst = {op, rs, rt, imm};
    r.predict_pc_addr = $urandom; r.predict_brunch_taken = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic logic exp_ready();
    return rst_done && (q.size() < 2);
  endfunction

  task automatic chk(input string tag, input logic [511:0] o, input logic [511:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Inputs are set during the low phase; model commits transfers at the rising edge.
  task automatic cyc();
    bit acc, drn, fl;
    bundle_t b;
    #4;
    fl  = flush;
    acc = in_valid && exp_ready() && !fl && (|in_slot_valid);
    drn = (q.size() > 0) && out_ready;
    b   = expect_bundle(in_req, in_slot_valid);
    @(posedge clk);
    if (rst || fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    rst_done = !rst;
    @(negedge clk);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".out_valid"}, 512'(out_valid), 512'(q.size() > 0));
    chk({tag, ".in_ready"}, 512'(in_ready), 512'(exp_ready()));
    if (q.size() > 0) begin
      chk({tag, ".elem"}, 512'(out_elem), 512'(q[0].e));
      chk({tag, ".slot"}, 512'(out_slot_valid), 512'(q[0].sv));
      chk({tag, ".ill"}, 512'(out_illegal), 512'(q[0].ill));
    end
  endtask

  initial begin
    issue_elem_t [W-1:0] snap;
    logic [31:0] pc1, pc2, pc3;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_req = '0; in_slot_valid = '0;
    #1;
    chk("rst.out_valid", 512'(out_valid), 512'(0));
    chk("rst.in_ready", 512'(in_ready), 512'(0));
    chk("rst.slot", 512'(out_slot_valid), 512'(0));
    chk("rst.ill", 512'(out_illegal), 512'(0));
    chk("rst.elem", 512'(out_elem), 512'({dflt(), dflt()}));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cyc(); chk_state("post_rst");

    // ORI / ADDIU immediate extension
    in_req[0] = mk(OP_ORI, 5'd1, 5'd2, 16'h8001);
    in_req[1] = mk(OP_ADDIU, 5'd3, 5'd4, 16'h8001);
    in_slot_valid = 2'b11; in_valid = 1'b1; out_ready = 1'b1;
    cyc(); in_valid = 1'b0;
    chk_state("imm");
    chk("imm.num2_0", 512'(out_elem[0].num2), 512'(32'h00008001));
    chk("imm.num2_1", 512'(out_elem[1].num2), 512'(32'hFFFF8001));
    chk("imm.alu_0", 512'(out_elem[0].alu_op), 512'(alu_or));
    chk("imm.alu_1", 512'(out_elem[1].alu_op), 512'(alu_add));
    chk("imm.wa_0", 512'(out_elem[0].write_reg_addr), 512'(5'd2));
    chk("imm.wa_1", 512'(out_elem[1].write_reg_addr), 512'(5'd4));
    chk("imm.ill", 512'(out_illegal), 512'(2'b00));
    cyc(); chk_state("imm_drain");

    // unknown opcode on lane1 only
    in_req[0] = mk(OP_ORI, 5'd7, 5'd8, 16'h0001);
    in_req[1] = mk(6'h3F, 5'd9, 5'd10, 16'h0002);
    in_slot_valid = 2'b10; in_valid = 1'b1;
    cyc(); in_valid = 1'b0;
    chk_state("bad");
    chk("bad.ill", 512'(out_illegal), 512'(2'b10));
    chk("bad.slot", 512'(out_slot_valid), 512'(2'b10));
    chk("bad.wr_need", 512'(out_elem[1].write_reg_need), 512'(0));
    chk("bad.lane0_dflt", 512'(out_elem[0]), 512'(dflt()));
    cyc();

    // LUI
    in_req[0] = mk(OP_LUI, 5'd0, 5'd5, 16'h1234);
    in_slot_valid = 2'b01; in_valid = 1'b1;
    cyc(); in_valid = 1'b0;
    chk_state("lui");
`ifdef DECODE_LOGIC_IMM_EXT_EN
    chk("lui.num2", 512'(out_elem[0].num2), 512'(32'h12340000));
    chk("lui.ill", 512'(out_illegal), 512'(2'b00));
`else
    chk("lui.ill", 512'(out_illegal), 512'(2'b01));
`endif
    cyc();

    // stall: b1 in output, b2 in skid, b3 held off
    out_ready = 1'b0; in_slot_valid = 2'b11; in_valid = 1'b1;
    in_req[0] = mk(OP_ORI, 5'd1, 5'd1, 16'h0011); in_req[1] = mk(OP_ADDIU, 5'd2, 5'd2, 16'h0022);
    pc1 = in_req[0].pc;
    cyc(); chk_state("stall1"); snap = out_elem;
    in_req[0] = mk(OP_ORI, 5'd3, 5'd3, 16'h0033); in_req[1] = mk(6'h20, 5'd4, 5'd4, 16'h0044);
    pc2 = in_req[0].pc;
    cyc(); chk_state("stall2");
    chk("stall2.in_ready", 512'(in_ready), 512'(0));
    chk("stall2.stable", 512'(out_elem), 512'(snap));
    in_req[0] = mk(OP_ADDIU, 5'd5, 5'd5, 16'hF055); in_req[1] = mk(OP_ORI, 5'd6, 5'd6, 16'h0066);
    pc3 = in_req[0].pc;
    cyc(); chk_state("stall3");
    chk("stall3.stable", 512'(out_elem), 512'(snap));
    chk("stall3.pc1", 512'(out_elem[0].pc), 512'(pc1));
    out_ready = 1'b1;
    cyc(); chk_state("rel1");
    chk("rel1.pc2", 512'(out_elem[0].pc), 512'(pc2));
    cyc(); in_valid = 1'b0; chk_state("rel2");
    chk("rel2.pc3", 512'(out_elem[0].pc), 512'(pc3));
    cyc(); chk_state("rel3");

    // flush with output and skid full plus an incoming bundle
    out_ready = 1'b0; in_valid = 1'b1;
    in_req[0] = mk(OP_ORI, 5'd1, 5'd2, 16'h0101); cyc();
    in_req[0] = mk(OP_ORI, 5'd1, 5'd2, 16'h0202); cyc(); chk_state("pre_flush");
    flush = 1'b1; in_req[0] = mk(OP_ORI, 5'd1, 5'd2, 16'h0303);
    cyc(); flush = 1'b0; in_valid = 1'b0;
    chk("flush.out_valid", 512'(out_valid), 512'(0));
    chk("flush.in_ready", 512'(in_ready), 512'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin cyc(); chk_state("post_flush"); end

    // asynchronous reset mid-stall
    out_ready = 1'b0; in_valid = 1'b1; in_req[0] = mk(OP_ORI, 5'd1, 5'd2, 16'h0404);
    cyc(); in_valid = 1'b0; chk_state("pre_rst");
    #2 rst = 1'b1;
    #1;
    chk("arst.out_valid", 512'(out_valid), 512'(0));
    chk("arst.in_ready", 512'(in_ready), 512'(0));
    chk("arst.slot", 512'(out_slot_valid), 512'(0));
    q.delete(); rst_done = 1'b0;
    @(negedge clk); rst = 1'b0;
    chk("arst.rel_ready", 512'(in_ready), 512'(0));
    cyc(); chk_state("arst_after");
    chk("arst.in_ready1", 512'(in_ready), 512'(1));

    // random traffic
    for (int n = 0; n < 400; n++) begin
      flush = ($urandom_range(0, 19) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_slot_valid = 2'($urandom);
      for (int l = 0; l < W; l++) begin
        logic [5:0] op;
        case ($urandom_range(0, 5))
          0: op = OP_ORI; 1: op = OP_ADDIU; 2: op = OP_ANDI;
          3: op = OP_XORI; 4: op = OP_LUI; default: op = 6'($urandom);
        endcase
        in_req[l] = mk(op, 5'($urandom), 5'($urandom), 16'($urandom));
      end
      cyc(); chk_state("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
